// File: rtl/nms_window_sequencer.sv
// Raster-scan sequencer for a combinational 3x3 non-max-suppression datapath:
// two line buffers, a 3x3 shift window, border forcing and valid/ready output staging.
module nms_window_sequencer #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned MAG_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAG_W-1:0]   in_mag,
    input  logic [1:0]         in_dir,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [9*MAG_W-1:0] win_mag,
    output logic [17:0]        win_dir,
    output logic               win_valid,
    input  logic [MAG_W-1:0]   nms_pixel,
    input  logic               nms_valid,
    output logic [MAG_W-1:0]   out_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

    localparam int unsigned PW = MAG_W + 2;
    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W * IMG_H + 1);
    localparam logic [XW-1:0] COL_LAST     = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST     = YW'(IMG_H - 1);
    localparam logic [CW-1:0] CNT_FILL_END = CW'(IMG_W);
    localparam logic [CW-1:0] CNT_RUN_END  = CW'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_LAST
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_in_cnt;
    logic [XW-1:0]   r_x;
    logic [XW-1:0]   r_cen_col;
    logic [YW-1:0]   r_cen_row;
    logic [PW-1:0]   r_win [3][3];
    logic [PW-1:0]   r_lb0 [IMG_W];
    logic [PW-1:0]   r_lb1 [IMG_W];
    logic            r_win_valid;
    logic            r_win_border;
    logic            r_win_last;
    logic [MAG_W-1:0] r_out_pixel;
    logic            r_out_valid;
    logic            r_out_last;

    logic            w_advance;
    logic            w_accept;
    logic            w_shift;
    logic            w_emit;
    logic            w_cen_border;
    logic            w_cen_last;
    logic [PW-1:0]   w_new;
    logic [PW-1:0]   w_row_in [3];

    assign w_advance    = !r_out_valid || out_ready;
    assign in_ready     = w_advance && (r_state == S_FILL || r_state == S_RUN);
    assign w_accept     = in_valid && in_ready;
    assign w_shift      = w_accept || (r_state == S_FLUSH && w_advance);
    assign w_emit       = w_shift && (r_state == S_RUN || r_state == S_FLUSH);
    assign w_cen_border = (r_cen_row == '0) || (r_cen_row == ROW_LAST) ||
                          (r_cen_col == '0) || (r_cen_col == COL_LAST);
    assign w_cen_last   = (r_cen_row == ROW_LAST) && (r_cen_col == COL_LAST);
    // Flush cycles push zero pseudo-pixels so the last line's centres complete.
    assign w_new        = w_accept ? {in_dir, in_mag} : '0;

    // Line buffers indexed by column: lb1 holds the previous line, lb0 the one before.
    always_comb begin
        w_row_in[0] = r_lb0[r_x];
        w_row_in[1] = r_lb1[r_x];
        w_row_in[2] = w_new;
    end

    always_comb begin
        win_mag = '0;
        win_dir = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                win_mag[(r*3+c)*MAG_W +: MAG_W] = r_win[r][c][MAG_W-1:0];
                win_dir[(r*3+c)*2 +: 2]         = r_win[r][c][MAG_W +: 2];
            end
        end
    end

    assign win_valid = r_win_valid;
    assign out_pixel = r_out_pixel;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FILL;
            S_FILL:  if (w_accept && r_in_cnt == CNT_FILL_END) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && r_in_cnt == CNT_RUN_END) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_emit && w_cen_last) w_state_nxt = S_LAST;
            S_LAST:  if (r_out_valid && out_ready && r_out_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_in_cnt     <= '0;
            r_x          <= '0;
            r_cen_col    <= '0;
            r_cen_row    <= '0;
            r_win_valid  <= 1'b0;
            r_win_border <= 1'b0;
            r_win_last   <= 1'b0;
            r_out_pixel  <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_in_cnt  <= '0;
                r_x       <= '0;
                r_cen_col <= '0;
                r_cen_row <= '0;
            end else begin
                if (w_accept) begin
                    r_in_cnt <= r_in_cnt + 1'b1;
                end
                if (w_shift) begin
                    r_x <= (r_x == COL_LAST) ? '0 : r_x + 1'b1;
                end
                if (w_emit) begin
                    if (r_cen_col == COL_LAST) begin
                        r_cen_col <= '0;
                        r_cen_row <= r_cen_row + 1'b1;
                    end else begin
                        r_cen_col <= r_cen_col + 1'b1;
                    end
                end
            end

            if (w_shift) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                    r_win[r][2] <= w_row_in[r];
                end
            end

            if (w_advance) begin
                r_win_valid  <= w_emit;
                r_win_border <= w_emit && w_cen_border;
                r_win_last   <= w_emit && w_cen_last;
                r_out_valid  <= nms_valid;
                r_out_last   <= nms_valid && r_win_last;
                if (nms_valid) begin
                    r_out_pixel <= r_win_border ? '0 : nms_pixel;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_lb0[r_x] <= r_lb1[r_x];
            r_lb1[r_x] <= w_new;
        end
    end

endmodule

// File: tb/tb_nms_window_sequencer.sv
// Bench for nms_window_sequencer on a 4x4 frame: table-driven frames, random frames
// against a coordinate-based NMS reference, backpressure, bubbles and mid-frame reset.
module tb_nms_window_sequencer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] in_mag;
    logic [1:0]  in_dir;
    logic        in_valid;
    logic        in_ready;
    logic [98:0] win_mag;
    logic [17:0] win_dir;
    logic        win_valid;
    logic [10:0] nms_pixel;
    logic        nms_valid;
    logic [10:0] out_pixel;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    nms_window_sequencer #(.IMG_W(W), .IMG_H(H), .MAG_W(11)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_mag    (in_mag),
        .in_dir    (in_dir),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_mag   (win_mag),
        .win_dir   (win_dir),
        .win_valid (win_valid),
        .nms_pixel (nms_pixel),
        .nms_valid (nms_valid),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    // External NMS datapath stand-in: keep centre only if strictly above both neighbours.
    logic [10:0] nm_c, nm_a, nm_b;
    always_comb begin
        nm_c = win_mag[44 +: 11];
        nm_a = '0;
        nm_b = '0;
        case (win_dir[9:8])
            2'd0:    begin nm_a = win_mag[33 +: 11]; nm_b = win_mag[55 +: 11]; end
            2'd1:    begin nm_a = win_mag[22 +: 11]; nm_b = win_mag[66 +: 11]; end
            2'd2:    begin nm_a = win_mag[11 +: 11]; nm_b = win_mag[77 +: 11]; end
            default: begin nm_a = win_mag[0 +: 11];  nm_b = win_mag[88 +: 11]; end
        endcase
        nms_pixel = (nm_c > nm_a && nm_c > nm_b) ? nm_c : '0;
    end
    assign nms_valid = win_valid;

    int total = 0;
    int bad   = 0;
    int fm[N];
    int fd[N];
    int expv[N];
    logic [10:0] got[$];
    logic        lastq[$];

    typedef struct {
        int base;
        int ia;
        int va;
        int ib;
        int vb;
        bit bubbles;
        int stall_at;
        int exp_idx;
        int exp_val;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_px(int idx);
        int r, c, m, a, b;
        r = idx / W;
        c = idx % W;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        m = fm[idx];
        case (fd[idx])
            0:       begin a = fm[idx - 1];             b = fm[idx + 1]; end
            1:       begin a = fm[(r-1)*W + c + 1];     b = fm[(r+1)*W + c - 1]; end
            2:       begin a = fm[idx - W];             b = fm[idx + W]; end
            default: begin a = fm[(r-1)*W + c - 1];     b = fm[(r+1)*W + c + 1]; end
        endcase
        return (m > a && m > b) ? m : 0;
    endfunction

    task automatic run_frame(input string tag, input bit bubbles, input int stall_at,
                             input bit start_mid, input int abort_after);
        int sent, cyc, stall_left;
        bit stalled, done, seen_last, mid_done;
        logic [10:0] hold_px;
        logic        hold_last;
        logic [98:0] hold_win;
        sent = 0; cyc = 0; stall_left = 0;
        stalled = 0; done = 0; seen_last = 0; mid_done = 0;
        hold_px = '0; hold_last = 1'b0; hold_win = '0;
        got.delete();
        lastq.delete();
        start = 1'b1;
        while (!done && cyc < 600) begin
            in_valid = (sent < N) && (!bubbles || (cyc % 2 == 0));
            in_mag   = (sent < N) ? 11'(fm[sent]) : '0;
            in_dir   = (sent < N) ? 2'(fd[sent]) : '0;
            if (!stalled && stall_at >= 0 && got.size() == stall_at && out_valid) begin
                stalled    = 1;
                stall_left = 5;
            end
            out_ready = (stall_left == 0);
            @(negedge clk);
            if (cyc == 0) check($sformatf("%s_idle_rdy", tag), in_ready, 0);
            if (stall_left > 0) begin
                if (stall_left == 5) begin
                    hold_px   = out_pixel;
                    hold_last = out_last;
                    hold_win  = win_mag;
                end else begin
                    check($sformatf("%s_hold_px", tag), out_pixel, hold_px);
                    check($sformatf("%s_hold_last", tag), out_last, hold_last);
                    check($sformatf("%s_hold_win", tag), win_mag == hold_win, 1);
                    check($sformatf("%s_stall_rdy", tag), in_ready, 0);
                end
                stall_left--;
            end
            if (seen_last) begin
                check($sformatf("%s_busy_end", tag), busy, 0);
                check($sformatf("%s_valid_end", tag), out_valid, 0);
                done = 1;
            end else begin
                if (out_valid && out_ready) begin
                    got.push_back(out_pixel);
                    lastq.push_back(out_last);
                    if (out_last) seen_last = 1;
                end
                if (in_valid && in_ready) sent++;
            end
            if (abort_after >= 0 && sent == abort_after) done = 1;
            @(posedge clk);
            #1;
            if (start_mid && !mid_done && sent >= 3) begin
                start    = 1'b1;
                mid_done = 1;
            end else begin
                start = 1'b0;
            end
            cyc++;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!done) check($sformatf("%s_timeout", tag), 1, 0);
    endtask

    task automatic compare_frame(input string tag);
        check($sformatf("%s_count", tag), got.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < got.size()) begin
                check($sformatf("%s_px%0d", tag, i), got[i], expv[i]);
                check($sformatf("%s_last%0d", tag, i), lastq[i], (i == N - 1));
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < N; i++) begin
            fm[i]   = v.base;
            fd[i]   = 0;
            expv[i] = (i == v.exp_idx) ? v.exp_val : 0;
        end
        if (v.ia >= 0) fm[v.ia] = v.va;
        if (v.ib >= 0) fm[v.ib] = v.vb;
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_in_ready", tag), in_ready, 0);
        check($sformatf("%s_win_valid", tag), win_valid, 0);
        check($sformatf("%s_win_mag", tag), win_mag == '0, 1);
        check($sformatf("%s_win_dir", tag), win_dir, 0);
        check($sformatf("%s_out_valid", tag), out_valid, 0);
        check($sformatf("%s_out_pixel", tag), out_pixel, 0);
        check($sformatf("%s_out_last", tag), out_last, 0);
        check($sformatf("%s_busy", tag), busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{10, 5, 100, -1, 0, 1'b0, -1, 5, 100};
        vecs[1] = '{10, 5, 100,  6, 100, 1'b0, -1, -1, 0};
        vecs[2] = '{1,  0, 500, 15, 500, 1'b0, -1, -1, 0};
        vecs[3] = '{10, 5, 100, -1, 0, 1'b0,  6, 5, 100};
        vecs[4] = '{10, 5, 100, -1, 0, 1'b1, -1, 5, 100};
        vecs[5] = '{10, 10, 200, -1, 0, 1'b1, 3, 10, 200};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_mag = '0; in_dir = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        in_valid = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        for (int t = 0; t < 6; t++) begin
            load_vec(vecs[t]);
            run_frame($sformatf("vec%0d", t), vecs[t].bubbles, vecs[t].stall_at, 1'b0, -1);
            compare_frame($sformatf("vec%0d", t));
        end

        // Reset mid-frame after 7 inputs, then a fresh frame with a stray start while busy.
        load_vec(vecs[0]);
        run_frame("abort", 1'b0, -1, 1'b0, 7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        run_frame("fresh", 1'b0, -1, 1'b1, -1);
        compare_frame("fresh");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fresh_no_restart", busy, 0);
        @(posedge clk);
        #1;

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                fm[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                                    : int'($urandom_range(0, 20));
                fd[i] = int'($urandom_range(0, 3));
            end
            for (int i = 0; i < N; i++) expv[i] = ref_px(i);
            run_frame($sformatf("rnd%0d", f), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 14)), 1'b0, -1);
            compare_frame($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
